spi_reg_responder: RTL and testbench

- SPI responder (mode 0, MSB first, active-low cs) that decodes 3-byte command/address/data frames from the SPI master and serves them from an internal register bank.
- The bank holds DEPTH bytes; write frames update the bank, read frames return bank contents on miso.
- sck, cs and mosi are oversampled in the system clock domain.
- Sits on the serial side of the SPI link, opposite the master's command/address/data sequencer.

---
 rtl/spi_reg_responder.sv | 196 +++++++++++++++++++
 tb/tb_spi_reg_responder.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/spi_reg_responder.sv
// SPI mode-0 responder serving a DEPTH x 8-bit register bank over cmd/addr/data frames.
// Define SPI_REG_AUTOINC_EN to stream consecutive data bytes with address auto-increment.
module spi_reg_responder #(
  parameter int unsigned DEPTH     = 16,
  parameter logic [7:0]  CMD_WRITE = 8'h01,
  parameter logic [7:0]  CMD_READ  = 8'h02
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cs,
  input  logic       sck,
  input  logic       mosi,
  output logic       miso,
  output logic       wr_valid,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       frame_done,
  output logic       err
);

  localparam int unsigned AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [8:0]  DEPTH_W = 9'(DEPTH);

  typedef enum logic [2:0] {StIdle, StCmd, StAddr, StData, StIgnore} state_e;
  state_e state_q, state_d;

  logic cs_meta_q, cs_sync_q, cs_prev_q;
  logic sck_meta_q, sck_sync_q, sck_prev_q;
  logic mosi_meta_q, mosi_sync_q;

  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [6:0] rx_q, rx_d;
  logic       cmd_rd_q, cmd_rd_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] tx_q, tx_d;
  logic       err_q, err_d;
  logic       wr_fire;
  logic       wr_valid_q, frame_done_q, fd_pend_q;
  logic [7:0] wr_addr_q, wr_data_q;
  logic [7:0] regs_q [DEPTH];

  logic       cs_fall, cs_rise, sck_rise, sck_fall, active, byte_done, cmd_ok;
  logic [7:0] rx_byte, addr_inc, rd_sel, rd_data;

  function automatic logic addr_ok(input logic [7:0] a);
    return {1'b0, a} < DEPTH_W;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cs_meta_q   <= 1'b1;
      cs_sync_q   <= 1'b1;
      cs_prev_q   <= 1'b1;
      sck_meta_q  <= 1'b0;
      sck_sync_q  <= 1'b0;
      sck_prev_q  <= 1'b0;
      mosi_meta_q <= 1'b0;
      mosi_sync_q <= 1'b0;
    end else begin
      cs_meta_q   <= cs;
      cs_sync_q   <= cs_meta_q;
      cs_prev_q   <= cs_sync_q;
      sck_meta_q  <= sck;
      sck_sync_q  <= sck_meta_q;
      sck_prev_q  <= sck_sync_q;
      mosi_meta_q <= mosi;
      mosi_sync_q <= mosi_meta_q;
    end
  end

  assign cs_fall   = cs_prev_q & ~cs_sync_q;
  assign cs_rise   = ~cs_prev_q & cs_sync_q;
  assign sck_rise  = ~sck_prev_q & sck_sync_q;
  assign sck_fall  = sck_prev_q & ~sck_sync_q;
  assign active    = (state_q == StCmd) || (state_q == StAddr) || (state_q == StData);
  assign byte_done = active && sck_rise && (bit_cnt_q == 3'd7);
  assign rx_byte   = {rx_q, mosi_sync_q};
  assign cmd_ok    = (rx_byte == CMD_WRITE) || (rx_byte == CMD_READ);
  assign addr_inc  = addr_q + 8'd1;
  // Bank read port serves both the initial load (address byte) and the auto-increment reload.
  assign rd_sel    = (state_q == StAddr) ? rx_byte : addr_inc;

  always_comb begin
    rd_data = 8'h00;
    if (addr_ok(rd_sel)) rd_data = regs_q[rd_sel[AW-1:0]];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (cs_fall) state_d = StCmd;
      StCmd:    if (byte_done) state_d = cmd_ok ? StAddr : StIgnore;
      StAddr:   if (byte_done) state_d = StData;
`ifdef SPI_REG_AUTOINC_EN
      StData:   state_d = StData;
`else
      StData:   if (byte_done) state_d = StIgnore;
`endif
      StIgnore: state_d = StIgnore;
      default:  state_d = StIdle;
    endcase
    // A byte completing in the same clk still commits before the abort takes effect.
    if (cs_rise) state_d = StIdle;
  end

  always_comb begin
    bit_cnt_d = bit_cnt_q;
    rx_d      = rx_q;
    cmd_rd_d  = cmd_rd_q;
    addr_d    = addr_q;
    tx_d      = tx_q;
    err_d     = err_q;
    wr_fire   = 1'b0;
    if (state_q == StIdle && cs_fall) begin
      bit_cnt_d = 3'd0;
      rx_d      = 7'd0;
    end
    if (active && sck_rise) begin
      rx_d      = rx_byte[6:0];
      bit_cnt_d = bit_cnt_q + 3'd1;
    end
    // The fall right after a byte boundary must not shift away the freshly loaded MSB.
    if (state_q == StData && sck_fall && bit_cnt_q != 3'd0) tx_d = {tx_q[6:0], 1'b0};
    if (byte_done) begin
      unique case (state_q)
        StCmd: begin
          if (cmd_ok) cmd_rd_d = (rx_byte == CMD_READ);
          else        err_d    = 1'b1;
        end
        StAddr: begin
          addr_d = rx_byte;
          tx_d   = rd_data;
        end
        StData: begin
          if (!addr_ok(addr_q)) err_d   = 1'b1;
          else if (!cmd_rd_q)   wr_fire = 1'b1;
`ifdef SPI_REG_AUTOINC_EN
          addr_d = addr_inc;
          if (cmd_rd_q) tx_d = rd_data;
`endif
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt_q    <= 3'd0;
      rx_q         <= 7'd0;
      cmd_rd_q     <= 1'b0;
      addr_q       <= 8'd0;
      tx_q         <= 8'd0;
      err_q        <= 1'b0;
      wr_valid_q   <= 1'b0;
      wr_addr_q    <= 8'd0;
      wr_data_q    <= 8'd0;
      frame_done_q <= 1'b0;
      fd_pend_q    <= 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) regs_q[i] <= 8'h00;
    end else begin
      bit_cnt_q  <= bit_cnt_d;
      rx_q       <= rx_d;
      cmd_rd_q   <= cmd_rd_d;
      addr_q     <= addr_d;
      tx_q       <= tx_d;
      err_q      <= err_d;
      wr_valid_q <= wr_fire;
      if (wr_fire) begin
        wr_addr_q                <= addr_q;
        wr_data_q                <= rx_byte;
        regs_q[addr_q[AW-1:0]]   <= rx_byte;
      end
      // frame_done slips one clk when it would coincide with wr_valid.
      frame_done_q <= (cs_rise & ~wr_fire) | fd_pend_q;
      fd_pend_q    <= cs_rise & wr_fire;
    end
  end

  always_comb begin
    miso = 1'b0;
    if (state_q == StData && cmd_rd_q && !cs_sync_q) miso = tx_q[7];
  end

  assign wr_valid   = wr_valid_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign frame_done = frame_done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_spi_reg_responder.sv
// Self-checking bench for spi_reg_responder (default build, DEPTH=16): directed vector
// table, hand-written corner sequences and random frames against a bank-level model.
module tb_spi_reg_responder;

  localparam int HALF  = 5;
  localparam int DEPTH = 16;

  logic       clk, rst, cs, sck, mosi;
  logic       miso, wr_valid, frame_done, err;
  logic [7:0] wr_addr, wr_data;

  spi_reg_responder #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .cs         (cs),
    .sck        (sck),
    .mosi       (mosi),
    .miso       (miso),
    .wr_valid   (wr_valid),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .frame_done (frame_done),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  int         wr_cnt = 0;
  int         fd_cnt = 0;
  int         both_cnt = 0;
  logic [7:0] last_wa = 8'h00;
  logic [7:0] last_wd = 8'h00;

  always @(negedge clk) begin
    if (wr_valid) begin
      wr_cnt  <= wr_cnt + 1;
      last_wa <= wr_addr;
      last_wd <= wr_data;
    end
    if (frame_done) fd_cnt <= fd_cnt + 1;
    if (wr_valid && frame_done) both_cnt <= both_cnt + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Frame bits go out MSB first from frame[31]; miso is captured just before each rise.
  task automatic spi_xfer(input logic [31:0] frame, input int nbits, input bit cs_last,
                          output logic [31:0] cap);
    cap = 32'h0;
    @(negedge clk);
    cs = 1'b0;
    repeat (6) @(negedge clk);
    for (int k = 0; k < nbits; k++) begin
      mosi = frame[31-k];
      repeat (HALF) @(negedge clk);
      cap[31-k] = miso;
      sck = 1'b1;
      if (cs_last && k == nbits - 1) cs = 1'b1;
      repeat (HALF) @(negedge clk);
      sck = 1'b0;
    end
    repeat (HALF) @(negedge clk);
    cs = 1'b1;
    repeat (12) @(negedge clk);
  endtask

  typedef struct {
    logic [31:0] frame;
    int          nbits;
    bit          cs_last;
    int          exp_wr;
    logic [7:0]  exp_wa;
    logic [7:0]  exp_wd;
    logic [31:0] exp_miso;
    logic        exp_err;
  } vec_t;

  vec_t vecs[12];

  task automatic run_vec(input int idx);
    int          w0, f0;
    logic [31:0] cap;
    w0 = wr_cnt;
    f0 = fd_cnt;
    spi_xfer(vecs[idx].frame, vecs[idx].nbits, vecs[idx].cs_last, cap);
    check($sformatf("vec%0d wr_count", idx), wr_cnt - w0, vecs[idx].exp_wr);
    if (vecs[idx].exp_wr != 0) begin
      check($sformatf("vec%0d wr_addr", idx), {24'h0, last_wa}, {24'h0, vecs[idx].exp_wa});
      check($sformatf("vec%0d wr_data", idx), {24'h0, last_wd}, {24'h0, vecs[idx].exp_wd});
    end
    check($sformatf("vec%0d miso", idx), cap, vecs[idx].exp_miso);
    check($sformatf("vec%0d frame_done", idx), fd_cnt - f0, 1);
    check($sformatf("vec%0d err", idx), {31'h0, err}, {31'h0, vecs[idx].exp_err});
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; cs = 1'b1; sck = 1'b0; mosi = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  logic [7:0]  model [256];
  logic        err_m;
  logic [31:0] cap;
  int          w0, f0;

  initial begin
    //          frame          bits cs_l wr wa     wd     miso           err
    vecs[0]  = '{32'h0105A500, 24, 1'b0, 1, 8'h05, 8'hA5, 32'h00000000, 1'b0};
    vecs[1]  = '{32'h02050000, 24, 1'b0, 0, 8'h00, 8'h00, 32'h0000A500, 1'b0};
    vecs[2]  = '{32'h01033C00, 24, 1'b0, 1, 8'h03, 8'h3C, 32'h00000000, 1'b0};
    vecs[3]  = '{32'h0103F000, 20, 1'b0, 0, 8'h00, 8'h00, 32'h00000000, 1'b0};
    vecs[4]  = '{32'h02030000, 24, 1'b0, 0, 8'h00, 8'h00, 32'h00003C00, 1'b0};
    vecs[5]  = '{32'h02050000, 32, 1'b0, 0, 8'h00, 8'h00, 32'h0000A500, 1'b0};
    vecs[6]  = '{32'h01067788, 32, 1'b0, 1, 8'h06, 8'h77, 32'h00000000, 1'b0};
    vecs[7]  = '{32'h02060000, 24, 1'b0, 0, 8'h00, 8'h00, 32'h00007700, 1'b0};
    vecs[8]  = '{32'h010FC300, 24, 1'b0, 1, 8'h0F, 8'hC3, 32'h00000000, 1'b0};
    vecs[9]  = '{32'h020F0000, 24, 1'b0, 0, 8'h00, 8'h00, 32'h0000C300, 1'b0};
    vecs[10] = '{32'h01201100, 24, 1'b0, 0, 8'h00, 8'h00, 32'h00000000, 1'b1};
    vecs[11] = '{32'h02200000, 24, 1'b0, 0, 8'h00, 8'h00, 32'h00000000, 1'b1};

    rst = 1'b1; cs = 1'b1; sck = 1'b0; mosi = 1'b0;
    repeat (3) @(negedge clk);
    check("reset miso", {31'h0, miso}, 32'h0);
    check("reset wr_valid", {31'h0, wr_valid}, 32'h0);
    check("reset wr_addr", {24'h0, wr_addr}, 32'h0);
    check("reset wr_data", {24'h0, wr_data}, 32'h0);
    check("reset frame_done", {31'h0, frame_done}, 32'h0);
    check("reset err", {31'h0, err}, 32'h0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    for (int i = 0; i < 12; i++) run_vec(i);

    // cs rises in the same clk as the final data rise: the write must still land.
    do_reset();
    w0 = wr_cnt; f0 = fd_cnt;
    spi_xfer(32'h01075A00, 24, 1'b1, cap);
    check("collide wr_count", wr_cnt - w0, 1);
    check("collide wr_data", {24'h0, last_wd}, 32'h5A);
    check("collide frame_done", fd_cnt - f0, 1);
    spi_xfer(32'h02070000, 24, 1'b0, cap);
    check("collide readback", cap, 32'h00005A00);

    // Bad command sets a sticky err that survives a later good frame.
    w0 = wr_cnt;
    spi_xfer(32'h7F053300, 24, 1'b0, cap);
    check("badcmd wr_count", wr_cnt - w0, 0);
    check("badcmd miso", cap, 32'h0);
    check("badcmd err", {31'h0, err}, 32'h1);
    spi_xfer(32'h01044400, 24, 1'b0, cap);
    check("badcmd good write", wr_cnt - w0, 1);
    check("badcmd err sticky", {31'h0, err}, 32'h1);

    // Reset mid-frame clears outputs and the bank.
    @(negedge clk);
    cs = 1'b0;
    repeat (6) @(negedge clk);
    for (int k = 0; k < 12; k++) begin
      mosi = k[0];
      repeat (HALF) @(negedge clk);
      sck = 1'b1;
      repeat (HALF) @(negedge clk);
      sck = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    check("midreset err", {31'h0, err}, 32'h0);
    check("midreset wr_addr", {24'h0, wr_addr}, 32'h0);
    check("midreset miso", {31'h0, miso}, 32'h0);
    cs = 1'b1; sck = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    spi_xfer(32'h02040000, 24, 1'b0, cap);
    check("midreset bank cleared", cap, 32'h0);

    // Random frames against a bank-level model.
    do_reset();
    for (int i = 0; i < 256; i++) model[i] = 8'h00;
    err_m = 1'b0;
    for (int t = 0; t < 40; t++) begin
      logic [7:0]  c, a, d, e, rv;
      int          nb, r;
      logic [31:0] exp_miso;
      bit          exp_wr;
      r = int'($urandom_range(0, 19));
      c = (r < 9) ? 8'h01 : (r < 18) ? 8'h02 : 8'($urandom);
      a = 8'($urandom_range(0, 19));
      d = 8'($urandom);
      e = 8'($urandom);
      nb = ($urandom_range(0, 9) < 7) ? 24 : int'($urandom_range(1, 32));
      exp_wr = (nb >= 24) && (c == 8'h01) && (a < DEPTH);
      if (nb >= 8 && c != 8'h01 && c != 8'h02) err_m = 1'b1;
      if (nb >= 24 && (c == 8'h01 || c == 8'h02) && a >= DEPTH) err_m = 1'b1;
      rv = (a < DEPTH) ? model[a] : 8'h00;
      exp_miso = 32'h0;
      if (c == 8'h02)
        for (int k = 16; k < 24 && k < nb; k++) exp_miso[31-k] = rv[23-k];
      w0 = wr_cnt; f0 = fd_cnt;
      spi_xfer({c, a, d, e}, nb, 1'b0, cap);
      check($sformatf("rnd%0d wr_count", t), wr_cnt - w0, exp_wr ? 1 : 0);
      if (exp_wr) begin
        model[a] = d;
        check($sformatf("rnd%0d wr_addr", t), {24'h0, last_wa}, {24'h0, a});
        check($sformatf("rnd%0d wr_data", t), {24'h0, last_wd}, {24'h0, d});
      end
      check($sformatf("rnd%0d miso", t), cap, exp_miso);
      check($sformatf("rnd%0d frame_done", t), fd_cnt - f0, 1);
      check($sformatf("rnd%0d err", t), {31'h0, err}, {31'h0, err_m});
    end

    check("wr_valid/frame_done overlap", both_cnt, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
